// File: rtl/wf_samp_capture_pkg.sv
// wf_samp_capture_pkg: shared definitions for the waterfall I/Q capture buffer.
//   - default widths (DW/AW/OW), drop-counter width
//   - write-side capture state encoding
//   - read command struct used to decode the fetch/pointer pulses
package wf_samp_capture_pkg;

  localparam int DW_DEF     = 16;  // matches CIC output width
  localparam int AW_DEF     = 10;  // 1024 I/Q pairs
  localparam int OW_DEF     = 12;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } cap_state_e;

  // One cycle's read-side pulses, highest priority first.
  typedef struct packed {
    logic rst;
    logic sync;
    logic q;
    logic i;
  } rd_req_t;

endpackage

// File: rtl/wf_capture_ram.sv
// wf_capture_ram: single-clock 2*DW x 2^AW RAM, one write port and one
// registered read port (read-before-write), written to infer block RAM.
//   adc_clk       clock
//   we/waddr      write enable / address
//   wdata         [1]=I, [0]=Q
//   re/raddr      read enable / address; rdata updates only when re=1
//   rdata         registered read data, [1]=I, [0]=Q (not reset)
module wf_capture_ram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic                 adc_clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [1:0][DW-1:0]   wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [1:0][DW-1:0]   rdata
);

  logic [2*DW-1:0] mem [2**AW];

  // Same-address write and read in one cycle returns the old word.
  always_ff @(posedge adc_clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wf_samp_capture.sv
// wf_samp_capture: I/Q capture buffer on adc_clk, downstream of the waterfall
// CIC pair. Single-shot or ring capture into wf_capture_ram, with a same-clock
// read port for the waterfall readout path.
//   adc_clk, adc_rst_n            clock, async active-low reset
//   wr_rst, wr_continuous         restart capture at 0, latch mode (1=ring)
//   wr, wr_i, wr_q                sample strobe and data
//   rd_rst, rd_sync, rd_offset    read pointer load: offset / wr_ptr+offset
//   rd_i, rd_q                    fetch I (no advance) / fetch Q (advance)
//   rd_iq                         read data, 1-cycle latency, holds
//   full, wr_ptr                  single-shot done, current write address
// Optional: define WF_CAPTURE_DROP_CNT_EN to add drop_cnt, a saturating count
// of strobes ignored while idle or full.
module wf_samp_capture
  import wf_samp_capture_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic                  adc_clk,
  input  logic                  adc_rst_n,
  input  logic                  wr_rst,
  input  logic                  wr_continuous,
  input  logic                  wr,
  input  logic [DW-1:0]         wr_i,
  input  logic [DW-1:0]         wr_q,
  input  logic                  rd_rst,
  input  logic                  rd_sync,
  input  logic [OW-1:0]         rd_offset,
  input  logic                  rd_i,
  input  logic                  rd_q,
  output logic [DW-1:0]         rd_iq,
`ifdef WF_CAPTURE_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
  output logic                  full,
  output logic [AW-1:0]         wr_ptr
);

  // ---------------- write side ----------------
  cap_state_e state, state_nxt;
  logic       mode;
  logic       we;

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    if (wr_rst) begin
      state_nxt = ST_FILL;                 // restart wins over a same-cycle wr
    end else begin
      case (state)
        ST_FILL: if (wr) begin
          we = 1'b1;
          if (!mode && (&wr_ptr)) state_nxt = ST_FULL;
        end
        default: ;
      endcase
    end
  end

  // wr_ptr simply wraps on the last write, so FULL sits at address 0.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state  <= ST_IDLE;
      mode   <= 1'b0;
      wr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (wr_rst) begin
        mode   <= wr_continuous;
        wr_ptr <= '0;
      end else if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  assign full = (state == ST_FULL);

`ifdef WF_CAPTURE_DROP_CNT_EN
  logic drop_hit;
  assign drop_hit = wr && !wr_rst && (state != ST_FILL);

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n)                  drop_cnt <= '0;
    else if (wr_rst)                 drop_cnt <= '0;
    else if (drop_hit && ~&drop_cnt) drop_cnt <= drop_cnt + 1'b1;
  end
`endif

  // ---------------- read side ----------------
  rd_req_t            req;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      off_a;
  logic               do_q, do_i, re;
  logic               sel_q, loaded;
  logic [1:0][DW-1:0] rdata;

  assign req   = '{rst: rd_rst, sync: rd_sync, q: rd_q, i: rd_i};
  assign off_a = AW'(rd_offset);           // zero-extend or truncate to AW
  assign do_q  = req.q && !req.rst && !req.sync;
  assign do_i  = req.i && !req.q && !req.rst && !req.sync;
  assign re    = do_q || do_i;

  // rd_sync uses the registered wr_ptr, i.e. the value before this cycle's write.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n)   rd_ptr <= '0;
    else if (req.rst)  rd_ptr <= off_a;
    else if (req.sync) rd_ptr <= wr_ptr + off_a;
    else if (do_q)     rd_ptr <= rd_ptr + 1'b1;
  end

  // RAM output register is not resettable; 'loaded' masks it to zero until
  // the first fetch after reset, so rd_iq still clears asynchronously.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      sel_q  <= 1'b0;
      loaded <= 1'b0;
    end else if (re) begin
      sel_q  <= do_q;
      loaded <= 1'b1;
    end
  end

  assign rd_iq = !loaded ? '0 : (sel_q ? rdata[0] : rdata[1]);

  wf_capture_ram #(.DW(DW), .AW(AW)) u_ram (
    .adc_clk (adc_clk),
    .we      (we),
    .waddr   (wr_ptr),
    .wdata   ({wr_i, wr_q}),
    .re      (re),
    .raddr   (rd_ptr),
    .rdata   (rdata)
  );

endmodule

// File: tb/tb_wf_samp_capture.sv
module tb_wf_samp_capture;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int OW = 12;
  localparam int DEPTH = 1 << AW;

  logic adc_clk = 0, adc_rst_n = 0;
  logic wr_rst = 0, wr_continuous = 0, wr = 0;
  logic [DW-1:0] wr_i = 0, wr_q = 0;
  logic rd_rst = 0, rd_sync = 0, rd_i = 0, rd_q = 0;
  logic [OW-1:0] rd_offset = 0;
  logic [DW-1:0] rd_iq;
  logic full;
  logic [AW-1:0] wr_ptr;
`ifdef WF_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  wf_samp_capture #(.DW(DW), .AW(AW), .OW(OW)) dut (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n), .wr_rst(wr_rst),
    .wr_continuous(wr_continuous), .wr(wr), .wr_i(wr_i), .wr_q(wr_q),
    .rd_rst(rd_rst), .rd_sync(rd_sync), .rd_offset(rd_offset),
    .rd_i(rd_i), .rd_q(rd_q), .rd_iq(rd_iq),
`ifdef WF_CAPTURE_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .full(full), .wr_ptr(wr_ptr));

  always #5 adc_clk = ~adc_clk;

  int checks = 0, errors = 0;

  // ---- reference model: capture buffer described by its rules ----
  logic [DW-1:0] m_i [DEPTH];
  logic [DW-1:0] m_q [DEPTH];
  bit            m_ok [DEPTH];
  bit  m_armed = 0, m_full = 0, m_ring = 0;
  int  m_wp = 0, m_rp = 0, m_drops = 0;

  logic [DW-1:0] exp_q [$];
  bit fetch_flag = 0;

  typedef struct {
    bit wrst, mode, w;
    logic [DW-1:0] i, q;
    bit rrst, rsync;
    logic [OW-1:0] off;
    bit ri, rq;
  } stim_t;

  function automatic stim_t nop();
    stim_t s;
    s.wrst = 0; s.mode = 0; s.w = 0; s.i = 0; s.q = 0;
    s.rrst = 0; s.rsync = 0; s.off = 0; s.ri = 0; s.rq = 0;
    return s;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_armed = 0; m_full = 0; m_ring = 0; m_wp = 0; m_rp = 0; m_drops = 0;
  endfunction

  // One clock cycle of stimulus; model updated by the spec's rules
  // (reads see memory before this cycle's write).
  task automatic cyc(stim_t s);
    @(negedge adc_clk);
    wr_rst = s.wrst; wr_continuous = s.mode; wr = s.w; wr_i = s.i; wr_q = s.q;
    rd_rst = s.rrst; rd_sync = s.rsync; rd_offset = s.off; rd_i = s.ri; rd_q = s.rq;
    fetch_flag = 0;
    if (s.rrst) m_rp = int'(s.off) % DEPTH;
    else if (s.rsync) m_rp = (m_wp + int'(s.off)) % DEPTH;
    else if (s.rq) begin
      if (m_ok[m_rp]) begin exp_q.push_back(m_q[m_rp]); fetch_flag = 1; end
      m_rp = (m_rp + 1) % DEPTH;
    end else if (s.ri) begin
      if (m_ok[m_rp]) begin exp_q.push_back(m_i[m_rp]); fetch_flag = 1; end
    end
    if (s.wrst) begin
      m_armed = 1; m_full = 0; m_wp = 0; m_ring = s.mode; m_drops = 0;
    end else if (s.w) begin
      if (m_armed) begin
        m_i[m_wp] = s.i; m_q[m_wp] = s.q; m_ok[m_wp] = 1;
        m_wp = (m_wp + 1) % DEPTH;
        if (!m_ring && m_wp == 0) begin m_armed = 0; m_full = 1; end
      end else if (m_drops < 16'hFFFF) m_drops++;
    end
    @(posedge adc_clk); #1;
    chk("full", 32'(full), 32'(m_full));
    chk("wr_ptr", 32'(wr_ptr), 32'(m_wp));
`ifdef WF_CAPTURE_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
  endtask

  task automatic write_n(int n, int base_i, int base_q);
    stim_t s;
    for (int k = 0; k < n; k++) begin
      s = nop(); s.w = 1; s.i = DW'(base_i + k); s.q = DW'(base_q + k);
      cyc(s);
    end
  endtask

  task automatic restart(bit mode);
    stim_t s;
    s = nop(); s.wrst = 1; s.mode = mode; cyc(s);
  endtask

  // Scoreboard monitor: a fetch seen at an edge presents data just after it.
  always @(posedge adc_clk) begin
    if (fetch_flag) begin
      logic [DW-1:0] e;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_iq_unexpected got %0h", rd_iq);
      end else begin
        e = exp_q.pop_front();
        if (rd_iq !== e) begin
          errors++;
          $display("FAIL rd_iq got %0h expected %0h @%0t", rd_iq, e, $time);
        end
      end
    end
  end

  initial begin
    stim_t s;
    for (int a = 0; a < DEPTH; a++) m_ok[a] = 0;
    #12;
    chk("rst_rd_iq", 32'(rd_iq), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_wr_ptr", 32'(wr_ptr), 0);
    adc_rst_n = 1;

    // single-shot fill
    restart(0);
    write_n(20, 0, 'h100);
    chk("ss_full", 32'(full), 1);
    chk("ss_wr_ptr", 32'(wr_ptr), 0);
    s = nop(); s.rrst = 1; cyc(s);
    for (int k = 0; k < DEPTH; k++) begin
      s = nop(); s.ri = 1; cyc(s);
      s = nop(); s.rq = 1; cyc(s);
    end

    // continuous wrap
    restart(1);
    write_n(20, 0, 'h200);
    chk("ring_full", 32'(full), 0);
    chk("ring_wr_ptr", 32'(wr_ptr), 4);
    s = nop(); s.rsync = 1; cyc(s);
    for (int k = 0; k < DEPTH; k++) begin
      s = nop(); s.ri = 1; cyc(s);
      s = nop(); s.rq = 1; cyc(s);
    end

    // offset: 4 + 14 -> 2 (upper offset bits truncated)
    s = nop(); s.rsync = 1; s.off = 12'hF0E; cyc(s);
    s = nop(); s.ri = 1; cyc(s);
    cyc(nop());
    chk("offset_i", 32'(rd_iq), 18);
    cyc(nop());
    chk("rd_iq_hold", 32'(rd_iq), 18);

    // wr_rst with wr: sample dropped
    s = nop(); s.wrst = 1; s.mode = 1; s.w = 1; s.i = 'hAAAA; s.q = 'hBBBB; cyc(s);
    chk("rst_wr_ptr0", 32'(wr_ptr), 0);
    // rd_rst with rd_q: pointer = offset, no advance
    s = nop(); s.rrst = 1; s.rq = 1; s.off = 5; cyc(s);
    s = nop(); s.ri = 1; cyc(s);
    // read-before-write at address 0
    s = nop(); s.rrst = 1; cyc(s);
    s = nop(); s.ri = 1; s.w = 1; s.i = 'h7777; s.q = 'h8888; cyc(s);
    s = nop(); s.rq = 1; cyc(s);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      s = nop();
      s.wrst  = ($urandom_range(0, 49) == 0);
      s.mode  = ($urandom_range(0, 3) != 0);
      s.w     = $urandom_range(0, 1);
      s.i     = DW'($urandom); s.q = DW'($urandom);
      s.rrst  = ($urandom_range(0, 19) == 0);
      s.rsync = ($urandom_range(0, 19) == 0);
      s.off   = OW'($urandom);
      s.rq    = ($urandom_range(0, 2) == 0);
      s.ri    = ($urandom_range(0, 2) == 0);
      cyc(s);
    end

    // async reset during FILL at wr_ptr = 7
    restart(1);
    write_n(7, 'h40, 'h50);
    s = nop(); s.ri = 1; cyc(s);
    cyc(nop());
    #2 adc_rst_n = 0;
    #1;
    chk("async_wr_ptr", 32'(wr_ptr), 0);
    chk("async_full", 32'(full), 0);
    chk("async_rd_iq", 32'(rd_iq), 0);
    #1 adc_rst_n = 1;
    model_reset();
    write_n(5, 'h60, 'h70);
    chk("idle_wr_ptr", 32'(wr_ptr), 0);
    chk("idle_rd_iq", 32'(rd_iq), 0);
    restart(0);
    write_n(3, 'h80, 'h90);

`ifdef WF_CAPTURE_DROP_CNT_EN
    restart(0);
    write_n(DEPTH, 0, 0);
    write_n(5, 0, 0);
    chk("drop5", 32'(drop_cnt), 5);
    restart(0);
    chk("drop_clr", 32'(drop_cnt), 0);
    write_n(DEPTH, 0, 0);
    write_n(70000, 0, 0);
    chk("drop_sat", 32'(drop_cnt), 32'hFFFF);
`endif

    cyc(nop());
    cyc(nop());
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
